// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Display geometry shared by vga_timing_gen and pixel_color, so the raster
//   size is defined in one place. Defaults describe 640x480 at 60 Hz with an
//   800x525 total raster.
//   Contents:
//     POS_W              width of the hpos/vpos counters
//     H_* / V_*          visible area, porches and sync widths (pixels/lines)
//     H_TOTAL / V_TOTAL  derived full-raster sizes
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int POS_W     = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One raster axis: a 0..TOTAL-1 wrap counter with enable, plus the
//   active-area and sync-window flags for the value the counter takes on the
//   next edge. The parent registers those flags itself, so every derived
//   output lines up with the registered count with zero relative latency.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset (count -> 0)
//     en           advance enable; count holds while low
//     count        registered position
//     wrap         high while en is set and count is TOTAL-1 (wraps this edge)
//     active_nxt   next count lies in [0, ACT_END)
//     sync_nxt     next count lies in [SYNC_START, SYNC_END)
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W          = POS_W,
  parameter int TOTAL      = H_TOTAL,
  parameter int ACT_END    = H_DISPLAY,
  parameter int SYNC_START = H_DISPLAY + H_FRONT,
  parameter int SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active_nxt,
  output logic         sync_nxt
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  // Window bounds may equal 2**W, so compare with one spare bit.
  localparam logic [W:0]   ACT_X  = (W+1)'(ACT_END);
  localparam logic [W:0]   SYNC_S = (W+1)'(SYNC_START);
  localparam logic [W:0]   SYNC_E = (W+1)'(SYNC_END);

  logic [W-1:0] count_nxt;
  logic [W:0]   count_nxt_x;

  assign wrap = en && (count == LAST);

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = wrap ? '0 : count + W'(1);
    end
  end

  assign count_nxt_x = {1'b0, count_nxt};
  assign active_nxt  = count_nxt_x < ACT_X;
  assign sync_nxt    = (count_nxt_x >= SYNC_S) && (count_nxt_x < SYNC_E);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing producer for pixel_color: hpos/vpos, visible, hsync/vsync
//   and line/frame strobes. Every output is registered on the same edge as
//   the counters, so on any cycle all outputs describe the same pixel.
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset (raster -> (0,0),
//                   syncs inactive, no strobes)
//     pix_en        pixel advance qualifier
//     hpos, vpos    current column / line
//     visible       inside the H_DISPLAY x V_DISPLAY active area
//     hsync, vsync  syncs, active level HSYNC_POL / VSYNC_POL
//     line_start    one-clk pulse on the edge where hpos wraps to 0
//     frame_start   one-clk pulse on the edge where (hpos,vpos) wraps to (0,0)
//     frame_cnt     frames started since reset, mod 256
//                   (port present only when VGA_FRAME_CNT_EN is defined)
//
//   pix_en is a one-way qualifier with no back-pressure: an edge with pix_en
//   high advances one pixel, an edge with pix_en low holds every level output
//   and drives both strobes low. There is no ready; the consumer must keep up.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             visible,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOT > (1 << POS_W) || V_TOT > (1 << POS_W)) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the position counter range");
  end

  logic h_wrap, h_act_nxt, h_sync_nxt;
  logic v_wrap, v_act_nxt, v_sync_nxt;

  vga_axis_counter #(
    .W          (POS_W),
    .TOTAL      (H_TOT),
    .ACT_END    (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en),
    .count      (hpos),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .sync_nxt   (h_sync_nxt)
  );

  // The line counter only moves on the pixel edge that ends a line, which
  // also makes vsync change exactly together with the hpos wrap.
  vga_axis_counter #(
    .W          (POS_W),
    .TOTAL      (V_TOT),
    .ACT_END    (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_en & h_wrap),
    .count      (vpos),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .sync_nxt   (v_sync_nxt)
  );

  // The flags describe the next counter values, so registering them here
  // keeps them aligned with hpos/vpos. With pix_en low the next values equal
  // the current ones, so the levels hold naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      visible     <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      visible     <= h_act_nxt & v_act_nxt;
      hsync       <= h_sync_nxt ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= v_sync_nxt ? VSYNC_POL : ~VSYNC_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (h_wrap & v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share one clock:
//     dut_a  default 640x480 geometry, active-low syncs (line-level timing)
//     dut_b  16x8 raster, active-high syncs (frame-level timing, frame_cnt)
//   A pixel-index model (position = index mod total) predicts every output
//   and is compared on every falling edge; directed checks with literal
//   expectations pin the model. Optional feature: VGA_FRAME_CNT_EN.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // ---------------------------------------------------------------- geometry
  localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VD = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_HT = A_HD + A_HF + A_HS + A_HB;
  localparam int A_TOT = A_HT * (A_VD + A_VF + A_VS + A_VB);

  localparam int B_HD = 8, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VD = 4, B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int B_HT = B_HD + B_HF + B_HS + B_HB;
  localparam int B_TOT = B_HT * (B_VD + B_VF + B_VS + B_VB);

`ifdef VGA_FRAME_CNT_EN
  localparam bit HAS_FC = 1'b1;
`else
  localparam bit HAS_FC = 1'b0;
`endif

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic       vis_a, hs_a, vs_a, ls_a, fs_a;
  logic       vis_b, hs_b, vs_b, ls_b, fs_b;
  logic [7:0] fc_a, fc_b;

  vga_timing_gen dut_a (
    .clk         (clk),
    .rst_n       (rst_a),
    .pix_en      (en_a),
    .hpos        (hpos_a),
    .vpos        (vpos_a),
    .visible     (vis_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .line_start  (ls_a),
    .frame_start (fs_a)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_a)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_b),
    .pix_en      (en_b),
    .hpos        (hpos_b),
    .vpos        (vpos_b),
    .visible     (vis_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .line_start  (ls_b),
    .frame_start (fs_b)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_b)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_a = 8'd0;
  assign fc_b = 8'd0;
`endif

  // ------------------------------------------------------------ scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected output bundle {hpos,vpos,visible,hsync,vsync,line_start,
  // frame_start,frame_cnt} for linear pixel index p.
  function automatic logic [32:0] exp_vec(
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs,
    input bit hpol, input bit vpol,
    input int p, input bit ls, input bit fs, input int fc);
    int   ht, h, v;
    logic hact, vact, vis;
    ht   = hd + hf + hs + hb;
    h    = p % ht;
    v    = p / ht;
    hact = (h >= hd + hf) && (h < hd + hf + hs);
    vact = (v >= vd + vf) && (v < vd + vf + vs);
    vis  = (h < hd) && (v < vd);
    return {10'(h), 10'(v), vis, hact ? hpol : ~hpol, vact ? vpol : ~vpol,
            ls, fs, HAS_FC ? 8'(fc) : 8'd0};
  endfunction

  // Model state: pixel index, strobes, frame count; known after first reset.
  int pa = 0, pb = 0, fca = 0, fcb = 0;
  bit lsa = 1'b0, fsa = 1'b0, ka = 1'b0;
  bit lsb = 1'b0, fsb = 1'b0, kb = 1'b0;

  always @(posedge clk) begin
    if (!rst_a) begin
      pa <= 0; lsa <= 1'b0; fsa <= 1'b0; fca <= 0; ka <= 1'b1;
    end else if (en_a) begin
      pa  <= (pa + 1) % A_TOT;
      lsa <= ((pa + 1) % A_HT) == 0;
      fsa <= ((pa + 1) % A_TOT) == 0;
      if (((pa + 1) % A_TOT) == 0) fca <= (fca + 1) % 256;
    end else begin
      lsa <= 1'b0; fsa <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      pb <= 0; lsb <= 1'b0; fsb <= 1'b0; fcb <= 0; kb <= 1'b1;
    end else if (en_b) begin
      pb  <= (pb + 1) % B_TOT;
      lsb <= ((pb + 1) % B_HT) == 0;
      fsb <= ((pb + 1) % B_TOT) == 0;
      if (((pb + 1) % B_TOT) == 0) fcb <= (fcb + 1) % 256;
    end else begin
      lsb <= 1'b0; fsb <= 1'b0;
    end
  end

  // Compare process: every falling edge once the model is known.
  always @(negedge clk) begin
    if (ka)
      check("cycle_a", {hpos_a, vpos_a, vis_a, hs_a, vs_a, ls_a, fs_a, fc_a},
            exp_vec(A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, 1'b0, 1'b0, pa, lsa, fsa, fca));
    if (kb)
      check("cycle_b", {hpos_b, vpos_b, vis_b, hs_b, vs_b, ls_b, fs_b, fc_b},
            exp_vec(B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, 1'b1, 1'b1, pb, lsb, fsb, fcb));
  end

  // ---------------------------------------------------------- driver tasks
  task automatic wait_a(input int h, input int v, input int budget, input string name);
    int n = 0;
    while (!(int'(hpos_a) == h && int'(vpos_a) == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(int'(hpos_a) == h && int'(vpos_a) == v))
      check(name, {hpos_a, vpos_a, 13'd0}, {10'(h), 10'(v), 13'd0});
  endtask

  task automatic wait_b(input int h, input int v, input int budget, input string name);
    int n = 0;
    while (!(int'(hpos_b) == h && int'(vpos_b) == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(int'(hpos_b) == h && int'(vpos_b) == v))
      check(name, {hpos_b, vpos_b, 13'd0}, {10'(h), 10'(v), 13'd0});
  endtask

  // Cycles from now until the next frame_start on dut_b, bounded.
  task automatic cycles_to_frame_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 2 * B_TOT);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int n, cnt, first, last, vs_cnt, hs_cnt, vis_cnt;
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, default geometry
    check("a_rst_hpos", 33'(hpos_a), 33'd0);
    check("a_rst_vpos", 33'(vpos_a), 33'd0);
    check("a_rst_levels", 33'({vis_a, hs_a, vs_a, ls_a, fs_a}), 33'b11100);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_first_step", 33'(hpos_a), 33'd1);

    // pix_en 1,0,0,1 at hpos 100
    wait_a(100, 0, 200, "a_wait_100");
    @(negedge clk); check("a_gate_0", 33'({hpos_a, hs_a}), {22'd0, 10'd101, 1'b1}); en_a = 1'b0;
    @(negedge clk); check("a_gate_1", 33'({hpos_a, hs_a}), {22'd0, 10'd101, 1'b1});
    @(negedge clk); check("a_gate_2", 33'({hpos_a, hs_a}), {22'd0, 10'd101, 1'b1}); en_a = 1'b1;
    @(negedge clk); check("a_gate_3", 33'({hpos_a, hs_a}), {22'd0, 10'd102, 1'b1});

    // Visible edge
    wait_a(639, 0, 700, "a_wait_639");
    check("a_vis_639", 33'(vis_a), 33'd1);
    @(negedge clk);
    check("a_vis_640", 33'({hpos_a, vis_a}), {22'd0, 10'd640, 1'b0});

    // hsync window over the rest of the line
    cnt = 0; first = -1; last = -1; n = 0;
    while (!(int'(hpos_a) == 799) && n < 300) begin
      if (!hs_a) begin
        cnt++;
        if (first < 0) first = int'(hpos_a);
        last = int'(hpos_a);
      end
      @(negedge clk);
      n++;
    end
    check("a_hsync_width", 33'(cnt), 33'd96);
    check("a_hsync_first", 33'(first), 33'd656);
    check("a_hsync_last", 33'(last), 33'd751);

    // Line wrap
    @(negedge clk);
    check("a_wrap", 33'({hpos_a, vpos_a, ls_a, fs_a}), {11'd0, 10'd0, 10'd1, 1'b1, 1'b0});
    @(negedge clk);
    check("a_ls_one_clk", 33'({hpos_a, ls_a}), {22'd0, 10'd1, 1'b0});

    // pix_en low across the line wrap delays line_start
    wait_a(799, 1, 900, "a_wait_799_1");
    en_a = 1'b0;
    @(negedge clk); check("a_hold_wrap_0", 33'({hpos_a, ls_a}), {22'd0, 10'd799, 1'b0});
    @(negedge clk); check("a_hold_wrap_1", 33'({hpos_a, ls_a}), {22'd0, 10'd799, 1'b0});
    en_a = 1'b1;
    @(negedge clk);
    check("a_late_ls", 33'({hpos_a, vpos_a, ls_a}), {12'd0, 10'd0, 10'd2, 1'b1});

    // Mid-line reset inside the hsync window
    wait_a(700, 2, 900, "a_wait_700_2");
    check("a_in_hsync", 33'(hs_a), 33'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("a_midrst", 33'({hpos_a, vpos_a, vis_a, hs_a, vs_a, ls_a, fs_a}),
          {8'd0, 10'd0, 10'd0, 5'b11100});
    rst_a = 1'b1;

    // Small raster, active-high syncs
    check("b_rst_levels", 33'({hpos_b, vpos_b, vis_b, hs_b, vs_b, ls_b, fs_b}),
          {8'd0, 10'd0, 10'd0, 5'b10000});
    rst_b = 1'b1;
    cycles_to_frame_b(n);
    check("b_first_frame", 33'(n), 33'd128);
    check("b_frame_wrap", 33'({hpos_b, vpos_b, ls_b, fs_b}), {11'd0, 10'd0, 10'd0, 2'b11});

    // One full frame: window occupancy
    n = 0; vs_cnt = 0; hs_cnt = 0; vis_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (vs_b)  vs_cnt++;
      if (hs_b)  hs_cnt++;
      if (vis_b) vis_cnt++;
    end while (!fs_b && n < 2 * B_TOT);
    check("b_frame_period", 33'(n), 33'd128);
    check("b_vsync_clks", 33'(vs_cnt), 33'd32);
    check("b_hsync_clks", 33'(hs_cnt), 33'd24);
    check("b_visible_clks", 33'(vis_cnt), 33'd32);

`ifdef VGA_FRAME_CNT_EN
    check("b_fc_2", 33'(fc_b), 33'd2);
    for (int f = 0; f < 255; f++) begin
      cycles_to_frame_b(n);
    end
    check("b_fc_257", 33'(fc_b), 33'd1);
`endif

    // Reset during vsync and hsync
    wait_b(12, 5, 200, "b_wait_12_5");
    check("b_in_sync", 33'({hs_b, vs_b}), 33'b11);
    rst_b = 1'b0;
    @(negedge clk);
    check("b_midrst", {hpos_b, vpos_b, vis_b, hs_b, vs_b, ls_b, fs_b, fc_b},
          {10'd0, 10'd0, 5'b10000, 8'd0});
    rst_b = 1'b1;
    cycles_to_frame_b(n);
    check("b_frame_after_rst", 33'(n), 33'd128);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
